// File: rtl/hazard_stall_unit.sv
// Decode-side hazard controller: load-use and multicycle-unit stalls, taken-branch flushes,
// and a busy scoreboard that tracks the pending multiplier destination register.
module hazard_stall_unit #(
  parameter int WIDTH   = 5,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RegS1D,
  input  logic [WIDTH-1:0] RegS2D,
  input  logic             MulOpD,
  input  logic [WIDTH-1:0] WriteRegE,
  input  logic             RegWE,
  input  logic             MemReadE,
  input  logic             MulStartE,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MulBusy,
  output logic             MulDone,
  output logic             MulErr
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] busy_reg_q, busy_reg_d;
  logic             mul_err_q, mul_err_d;

  logic lw_hit, mul_hit, stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      cnt_q      <= 4'd0;
      busy_reg_q <= '0;
      mul_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_reg_q <= busy_reg_d;
      mul_err_q  <= mul_err_d;
    end
  end

  // The final busy cycle accepts a new start without error so the unit can run back to back.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_reg_d = busy_reg_q;
    mul_err_d  = mul_err_q;
    unique case (state_q)
      RUN: begin
        if (MulStartE) begin
          busy_reg_d = WriteRegE;
          cnt_d      = CNT_LOAD;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          if (MulStartE) mul_err_d = 1'b1;
        end else if (MulStartE) begin
          busy_reg_d = WriteRegE;
          cnt_d      = CNT_LOAD;
          state_d    = BUSY;
        end else begin
          busy_reg_d = '0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    MulBusy = (state_q == BUSY);
    MulDone = (state_q == BUSY) && (cnt_q == 4'd0);
    MulErr  = mul_err_q;

    lw_hit  = MemReadE && RegWE && (WriteRegE != '0) &&
              ((WriteRegE == RegS1D) || (WriteRegE == RegS2D));
    mul_hit = MulBusy && (((busy_reg_q != '0) &&
              ((busy_reg_q == RegS1D) || (busy_reg_q == RegS2D))) || MulOpD);
    stall   = lw_hit || mul_hit;

    if (BranchTakenE) begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = stall;
      StallD = stall;
      FlushD = 1'b0;
      FlushE = stall;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: table-driven combinational vectors plus multicycle sequences,
// with expected output words queued at drive time and popped when the outputs are sampled.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] reg_s1_d, reg_s2_d, write_reg_e;
  logic       mul_op_d, reg_we, mem_read_e, mul_start_e, branch_taken_e;
  logic       stall_f, stall_d, flush_d, flush_e, mul_busy, mul_done, mul_err;

  typedef struct {
    logic [4:0] s1;
    logic [4:0] s2;
    logic       mulop;
    logic [4:0] wre;
    logic       regwe;
    logic       memread;
    logic       mulstart;
    logic       branch;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] exp;
    string      name;
  } vec_t;

  // Output word: {StallF, StallD, FlushD, FlushE, MulBusy, MulDone, MulErr}
  logic [6:0] exp_q[$];
  string      name_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  vec_t       tbl[10];

  hazard_stall_unit #(.WIDTH(5), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .RegS1D(reg_s1_d), .RegS2D(reg_s2_d), .MulOpD(mul_op_d),
    .WriteRegE(write_reg_e), .RegWE(reg_we), .MemReadE(mem_read_e),
    .MulStartE(mul_start_e), .BranchTakenE(branch_taken_e),
    .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d), .FlushE(flush_e),
    .MulBusy(mul_busy), .MulDone(mul_done), .MulErr(mul_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation timed out, got none required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic in_t mk(input logic [4:0] s1, input logic [4:0] s2, input logic mulop,
                             input logic [4:0] wre, input logic regwe, input logic memread,
                             input logic mulstart, input logic branch);
    in_t r;
    r.s1 = s1; r.s2 = s2; r.mulop = mulop; r.wre = wre;
    r.regwe = regwe; r.memread = memread; r.mulstart = mulstart; r.branch = branch;
    return r;
  endfunction

  task automatic drive(input in_t v);
    reg_s1_d       = v.s1;
    reg_s2_d       = v.s2;
    mul_op_d       = v.mulop;
    write_reg_e    = v.wre;
    reg_we         = v.regwe;
    mem_read_e     = v.memread;
    mul_start_e    = v.mulstart;
    branch_taken_e = v.branch;
  endtask

  task automatic checkOutput();
    logic [6:0] exp, act;
    string      nm;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL scoreboard: queue empty, got 0 entries required 1");
      miscompares++;
      return;
    end
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    act = {stall_f, stall_d, flush_d, flush_e, mul_busy, mul_done, mul_err};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b required %b (StallF StallD FlushD FlushE MulBusy MulDone MulErr)",
               nm, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, check on the falling edge, step to the next edge.
  task automatic applyStimulus(input in_t v, input logic [6:0] exp, input string nm);
    drive(v);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic assertReset(input logic [6:0] exp, input string nm);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 7'b0000000, "idle"};
    tbl[1] = '{mk(0, 7, 0, 7, 1, 1, 0, 0), 7'b1101000, "lw_use_s2"};
    tbl[2] = '{mk(0, 0, 0, 0, 1, 1, 0, 0), 7'b0000000, "lw_r0_no_hazard"};
    tbl[3] = '{mk(7, 0, 0, 7, 1, 1, 0, 0), 7'b1101000, "lw_use_s1"};
    tbl[4] = '{mk(7, 0, 0, 7, 0, 1, 0, 0), 7'b0000000, "lw_no_regwe"};
    tbl[5] = '{mk(7, 0, 0, 7, 1, 0, 0, 0), 7'b0000000, "alu_no_load"};
    tbl[6] = '{mk(3, 4, 0, 7, 1, 1, 0, 0), 7'b0000000, "lw_unrelated"};
    tbl[7] = '{mk(0, 7, 0, 7, 1, 1, 0, 1), 7'b0011000, "branch_over_lw"};
    tbl[8] = '{mk(1, 2, 0, 0, 0, 0, 0, 1), 7'b0011000, "branch_alone"};
    tbl[9] = '{mk(1, 2, 1, 0, 0, 0, 0, 0), 7'b0000000, "mulop_unit_idle"};

    drive(z);
    rst = 1'b0;
    #3;
    exp_q.push_back(7'b0000000);
    name_q.push_back("reset_state");
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) applyStimulus(tbl[i].in, tbl[i].exp, tbl[i].name);

    // Dependent instruction waits on multiplier destination r9.
    applyStimulus(mk(0, 0, 0, 9, 1, 0, 1, 0), 7'b0000000, "dep_start");
    applyStimulus(mk(9, 0, 0, 0, 0, 0, 0, 0), 7'b1101100, "dep_busy1");
    applyStimulus(mk(9, 0, 0, 0, 0, 0, 0, 0), 7'b1101100, "dep_busy2");
    applyStimulus(mk(9, 0, 0, 0, 0, 0, 0, 0), 7'b1101110, "dep_done");
    applyStimulus(mk(9, 0, 0, 0, 0, 0, 0, 0), 7'b0000000, "dep_release");

    // Structural hazard, then a back-to-back start in the done cycle.
    applyStimulus(mk(0, 0, 0, 12, 1, 0, 1, 0), 7'b0000000, "struct_start");
    applyStimulus(mk(1, 2, 1, 0, 0, 0, 0, 0), 7'b1101100, "struct_busy1");
    applyStimulus(mk(1, 2, 1, 0, 0, 0, 0, 0), 7'b1101100, "struct_busy2");
    applyStimulus(mk(1, 2, 1, 5, 1, 0, 1, 0), 7'b1101110, "b2b_start_in_done");
    applyStimulus(mk(5, 0, 0, 0, 0, 0, 0, 0), 7'b1101100, "b2b_new_busyreg");
    applyStimulus(mk(12, 0, 0, 0, 0, 0, 0, 0), 7'b0000100, "b2b_old_reg_free");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0), 7'b0000110, "b2b_done");
    applyStimulus(z, 7'b0000000, "b2b_idle");

    // Start while busy: sticky error, original operation unaffected.
    applyStimulus(mk(0, 0, 0, 9, 1, 0, 1, 0), 7'b0000000, "err_start");
    applyStimulus(mk(0, 0, 0, 4, 1, 0, 1, 0), 7'b0000100, "err_restart_busy");
    applyStimulus(mk(9, 0, 0, 0, 0, 0, 0, 0), 7'b1101101, "err_busyreg_kept");
    applyStimulus(mk(4, 0, 0, 0, 0, 0, 0, 0), 7'b0000111, "err_done_on_time");
    applyStimulus(z, 7'b0000001, "err_sticky");

    // Reset abandons an operation at Cnt=1 and clears the error.
    applyStimulus(mk(0, 0, 0, 6, 1, 0, 1, 0), 7'b0000001, "rst_mid_start");
    applyStimulus(mk(6, 0, 0, 0, 0, 0, 0, 0), 7'b1101101, "rst_mid_busy1");
    assertReset(7'b0000000, "rst_mid_busy_asserted");
    applyStimulus(mk(6, 0, 1, 0, 0, 0, 0, 0), 7'b0000000, "rst_after_run");
    applyStimulus(z, 7'b0000000, "rst_no_done_pulse");

    if (exp_q.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
